// File: rtl/nonce_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : nonce_search_ctrl
// Description : Sequences nonce generator and SHA-256 core; stops on first
//               digest <= target, on nonce exhaustion or on hash timeout.
//               Optional attempt counter: NONCE_SEARCH_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module nonce_search_ctrl #(
    parameter int NONCE_W        = 32,
    parameter int DIGEST_W       = 256,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [DIGEST_W-1:0] target,
    input  logic [NONCE_W-1:0]  nonce,
    input  logic                nonce_overflow,
    output logic                nonce_enable,
    output logic                nonce_restart,
    output logic                hash_start,
    output logic [NONCE_W-1:0]  hash_nonce,
    input  logic                hash_done,
    input  logic [DIGEST_W-1:0] hash_digest,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                timeout,
    output logic [NONCE_W-1:0]  golden_nonce,
    output logic [31:0]         attempts
);

    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_RESTART = 4'd1;
    localparam logic [3:0] c_ISSUE   = 4'd2;
    localparam logic [3:0] c_WAIT    = 4'd3;
    localparam logic [3:0] c_CHECK   = 4'd4;
    localparam logic [3:0] c_ADVANCE = 4'd5;
    localparam logic [3:0] c_FOUND   = 4'd6;
    localparam logic [3:0] c_EXHAUST = 4'd7;
    localparam logic [3:0] c_ERROR   = 4'd8;

    // Counter only needs to reach TIMEOUT_CYCLES-1.
    localparam int c_WCNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_WAIT_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(c_WAIT_LAST_I);

    logic [3:0]          r_state;
    logic [3:0]          w_state_nxt;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic [DIGEST_W-1:0] r_digest;
    logic                w_hit;
    logic                w_wdog_expire;
    logic                w_accept_start;
    logic                w_issue_hash;

    assign w_hit         = (r_digest <= target);
    assign w_wdog_expire = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == c_WAIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_accept_start = 1'b0;
        w_issue_hash   = 1'b0;
        nonce_restart  = 1'b0;
        nonce_enable   = 1'b0;
        busy           = 1'b0;
        case (r_state)
            c_IDLE, c_FOUND, c_EXHAUST, c_ERROR: begin
                if (start) begin
                    w_state_nxt    = c_RESTART;
                    w_accept_start = 1'b1;
                end
            end
            c_RESTART: begin
                nonce_restart = 1'b1;
                busy          = 1'b1;
                w_state_nxt   = c_ISSUE;
            end
            c_ISSUE: begin
                busy = 1'b1;
                if (nonce_overflow) begin
                    w_state_nxt = c_EXHAUST;
                end else begin
                    w_state_nxt  = c_WAIT;
                    w_issue_hash = 1'b1;
                end
            end
            c_WAIT: begin
                busy = 1'b1;
                // A digest arriving on the last permitted cycle beats the watchdog.
                if (hash_done) begin
                    w_state_nxt = c_CHECK;
                end else if (w_wdog_expire) begin
                    w_state_nxt = c_ERROR;
                end
            end
            c_CHECK: begin
                busy        = 1'b1;
                w_state_nxt = w_hit ? c_FOUND : c_ADVANCE;
            end
            c_ADVANCE: begin
                nonce_enable = 1'b1;
                busy         = 1'b1;
                w_state_nxt  = c_ISSUE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
        if (abort) begin
            w_state_nxt    = c_IDLE;
            w_accept_start = 1'b0;
            w_issue_hash   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hash_start   <= 1'b0;
            hash_nonce   <= '0;
            r_wait_cnt   <= '0;
            r_digest     <= '0;
            found        <= 1'b0;
            exhausted    <= 1'b0;
            timeout      <= 1'b0;
            golden_nonce <= '0;
        end else begin
            hash_start <= w_issue_hash;
            if (w_issue_hash) begin
                hash_nonce <= nonce;
            end
            if (r_state == c_ISSUE) begin
                r_wait_cnt <= '0;
            end else if (r_state == c_WAIT && r_wait_cnt != c_WAIT_LAST) begin
                r_wait_cnt <= r_wait_cnt + c_WCNT_W'(1);
            end
            if (r_state == c_WAIT && hash_done) begin
                r_digest <= hash_digest;
            end
            if (abort || w_accept_start) begin
                found     <= 1'b0;
                exhausted <= 1'b0;
                timeout   <= 1'b0;
            end else begin
                if (r_state == c_CHECK && w_state_nxt == c_FOUND) begin
                    found        <= 1'b1;
                    golden_nonce <= hash_nonce;
                end
                if (r_state == c_ISSUE && w_state_nxt == c_EXHAUST) begin
                    exhausted <= 1'b1;
                end
                if (r_state == c_WAIT && w_state_nxt == c_ERROR) begin
                    timeout <= 1'b1;
                end
            end
        end
    end

`ifdef NONCE_SEARCH_STATS_EN
    logic [31:0] r_attempts;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_attempts <= '0;
        end else if (w_accept_start) begin
            r_attempts <= '0;
        end else if (w_issue_hash && r_attempts != 32'hFFFF_FFFF) begin
            r_attempts <= r_attempts + 32'd1;
        end
    end

    assign attempts = r_attempts;
`else
    assign attempts = 32'd0;
`endif

endmodule
`default_nettype wire

// File: doc/nonce_search_ctrl.md
Name: nonce_search_ctrl

Overview:
- Sequencing controller directly downstream of the nonce generator.
- Restarts and advances the generator, hands each nonce to the SHA-256 hash core, and compares each digest against the difficulty target.
- Stops on the first hit (golden nonce), on nonce-space exhaustion, or on a hash-core timeout.
- Sits between the top-level mining control/status registers and the hash datapath.

Parameters:
NONCE_W, 32, nonce width; must match the generator.
DIGEST_W, 256, digest and target width.
TIMEOUT_CYCLES, 1024, maximum WAIT cycles per hash; 0 disables the watchdog.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  pulse: begin a new search
abort  in  1  pulse: cancel the search
target  in  DIGEST_W  hit threshold, unsigned
nonce  in  NONCE_W  current generator value
nonce_overflow  in  1  generator wrapped past all-ones
nonce_enable  out  1  one-cycle advance strobe to the generator
nonce_restart  out  1  one-cycle restart strobe to the generator
hash_start  out  1  one-cycle strobe to the hash core
hash_nonce  out  NONCE_W  nonce under test; stable from hash_start until the next ISSUE
hash_done  in  1  digest valid (sampled in WAIT only)
hash_digest  in  DIGEST_W  result from the hash core
busy  out  1  search in progress
found  out  1  sticky: hit
exhausted  out  1  sticky: nonce space exhausted
timeout  out  1  sticky: hash core did not respond
golden_nonce  out  NONCE_W  nonce that produced the hit
attempts  out  32  hashes issued (see Optional Feature)

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs reset to 0, including hash_nonce, golden_nonce and attempts.
- States: IDLE, RESTART, ISSUE, WAIT, CHECK, ADVANCE, FOUND, EXHAUST, ERROR.
- Output decode and busy:
  - nonce_restart is high only in RESTART; nonce_enable is high only in ADVANCE (Moore decode).
  - busy is high in RESTART, ISSUE, WAIT, CHECK and ADVANCE.
- IDLE / FOUND / EXHAUST / ERROR:
  - start moves to RESTART and clears found, exhausted and timeout.
  - golden_nonce holds its value.
- RESTART: lasts 1 cycle, then ISSUE. The generator reads 0 during ISSUE.
- ISSUE (1 cycle):
  - If nonce_overflow=1, go to EXHAUST and set exhausted. No hash is issued.
  - Otherwise, register hash_nonce<=nonce and pulse hash_start as a registered output, high only in the first WAIT cycle. Go to WAIT.
- WAIT:
  - A wait counter clears on entry.
  - On hash_done=1, capture hash_digest into an internal register and go to CHECK.
  - Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1, go to ERROR and set timeout.
  - If hash_done and the timeout limit fall in the same cycle, hash_done wins.
- CHECK (1 cycle): compare the captured digest against target, full DIGEST_W unsigned.
  - digest<=target: go to FOUND, set found, golden_nonce<=hash_nonce.
  - Otherwise go to ADVANCE.
- ADVANCE: lasts 1 cycle, then ISSUE.
- Minimum per-attempt cost: 4 cycles plus the hash latency.
- hash_done outside WAIT is ignored.
- start while busy is ignored.
- abort in any state:
  - Next state is IDLE.
  - Clears found, exhausted and timeout. golden_nonce holds.
  - abort wins over a same-cycle start.
- Reset mid-search: immediate return to IDLE with every output at 0.

Optional Feature:
- Macro: NONCE_SEARCH_STATS_EN.
- Defined:
  - attempts counts hash_start pulses and saturates at 32'hFFFF_FFFF.
  - attempts clears on start.
  - attempts holds through FOUND/EXHAUST/ERROR and through abort.
- Undefined: attempts is tied to 0 and the counter logic is omitted. The port list is identical in both builds.

Test Plan:
- Reset check: assert rst mid-WAIT -> next sample shows busy=0, found=0, hash_start=0, nonce_enable=0, nonce_restart=0, hash_nonce=0, golden_nonce=0.
- Basic hit:
  - Setup: generator model counts from 0; hash model has 3-cycle latency, returns digest all-ones except nonce 5 -> 256'h1; target=256'h00FF...FF.
  - Expected: nonce_restart pulses once; 6 hash_start pulses with hash_nonce 0..5; nonce_enable pulses 5 times; found=1, golden_nonce=5, busy=0; attempts=6 with the macro, 0 without.
- Equality boundary: target=256'h1234, digest for nonce 0 = 256'h1234 -> found=1, golden_nonce=0 after exactly 1 hash_start. Repeat with digest 256'h1235 -> no hit, and ADVANCE follows.
- Exhaustion: all digests miss; generator model raises nonce_overflow after its 4th advance -> exactly 4 hash_start pulses, exhausted=1, found=0, busy=0.
- Timeout: TIMEOUT_CYCLES=16, hash_done never asserted -> timeout=1 entering ERROR after exactly 16 WAIT cycles. A hash_done on cycle 16 instead gives CHECK, not ERROR.
- Abort/start interaction:
  - start pulsed during WAIT -> ignored.
  - abort during WAIT -> IDLE next cycle, busy=0.
  - Late hash_done -> ignored.
  - New start -> nonce_restart pulse, and the next hash_nonce=0.
